// File: rtl/loader_pkg.sv
// Shared types for the instruction-memory boot loader.
package loader_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StLoad,
      StWrite,
      StDone,
      StErr
   } state_e;

   localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word shift register shared by the header and payload phases.
module byte_packer
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr_i,
   input  logic        push_i,
   input  logic [7:0]  in_data_i,
   output logic [31:0] word_o,
   output logic        full_o
);

   localparam int unsigned CntW = $clog2(BYTES_PER_WORD);

   logic [31:0]     word_q, word_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // Asserted on the push that completes the word, so the FSM can advance on that edge.
   assign full_o = push_i && (cnt_q == CntW'(BYTES_PER_WORD - 1));
   assign word_o = word_q;

   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      if (clr_i) begin
         word_d = '0;
         cnt_d  = '0;
      end else if (push_i) begin
         word_d = {word_q[23:0], in_data_i};
         cnt_d  = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: length-prefixed byte stream in, one-cycle word writes to instruction memory out.
module imem_loader
   import loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [7:0]  in_data_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   output logic        imem_we_o,
   output logic [31:0] imem_waddr_o,
   output logic [31:0] imem_wdata_o,
   output logic        cpu_en_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o
);

   localparam int unsigned RemW = $clog2(MAX_WORDS + 1);

   state_e          state_q, state_d;
   logic [31:0]     addr_q, addr_d;
   logic [RemW-1:0] rem_q, rem_d;

   logic        push;
   logic        clr;
   logic        full;
   logic [31:0] word;
   logic [31:0] hdr_count;

   assign in_ready_o = (state_q == StHdr) || (state_q == StLoad);
   assign push       = in_valid_i && in_ready_o;
   // Count as it will read once the current byte lands; only meaningful when full is set.
   assign hdr_count  = {word[23:0], in_data_i};

   byte_packer u_byte_packer (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (clr),
      .push_i    (push),
      .in_data_i (in_data_i),
      .word_o    (word),
      .full_o    (full)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      clr     = 1'b0;
      unique case (state_q)
         StIdle, StDone, StErr: begin
            if (start_i) begin
               state_d = StHdr;
               addr_d  = BASE_ADDR;
               clr     = 1'b1;
            end
         end
         StHdr: begin
            if (full) begin
               if (hdr_count == '0) begin
                  state_d = StDone;
               end else if (hdr_count > MAX_WORDS) begin
                  state_d = StErr;
               end else begin
                  rem_d   = hdr_count[RemW-1:0];
                  state_d = StLoad;
               end
            end
         end
         StLoad: begin
            if (full) state_d = StWrite;
         end
         StWrite: begin
            addr_d  = addr_q + 32'd4;
            rem_d   = rem_q - 1'b1;
            state_d = (rem_q == RemW'(1)) ? StDone : StLoad;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         addr_q  <= BASE_ADDR;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
      end
   end

   assign imem_we_o    = (state_q == StWrite);
   assign imem_waddr_o = addr_q;
   assign imem_wdata_o = word;
   assign cpu_en_o     = (state_q == StDone);
   assign done_o       = (state_q == StDone);
   assign err_o        = (state_q == StErr);
   assign busy_o       = (state_q == StHdr) || (state_q == StLoad) || (state_q == StWrite);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader; a second instance with a non-zero base shares all inputs.
module tb_imem_loader;

   typedef struct packed {
      logic [31:0] off;
      logic [31:0] data;
   } wr_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;

   logic        in_ready0, we0, cpu_en0, busy0, done0, err0;
   logic [31:0] waddr0, wdata0;
   logic        in_ready1, we1, cpu_en1, busy1, done1, err1;
   logic [31:0] waddr1, wdata1;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int last_we_cyc = -100;
   wr_t exp_q[$];
   logic [31:0] prog [0:7];

   imem_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(1024)) dut0 (
      .clk(clk), .rst(rst), .start_i(start), .in_data_i(in_data), .in_valid_i(in_valid),
      .in_ready_o(in_ready0), .imem_we_o(we0), .imem_waddr_o(waddr0), .imem_wdata_o(wdata0),
      .cpu_en_o(cpu_en0), .busy_o(busy0), .done_o(done0), .err_o(err0)
   );

   imem_loader #(.BASE_ADDR(32'h100), .MAX_WORDS(1024)) dut1 (
      .clk(clk), .rst(rst), .start_i(start), .in_data_i(in_data), .in_valid_i(in_valid),
      .in_ready_o(in_ready1), .imem_we_o(we1), .imem_waddr_o(waddr1), .imem_wdata_o(wdata1),
      .cpu_en_o(cpu_en1), .busy_o(busy1), .done_o(done1), .err_o(err1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Write monitor: pops the scoreboard on every write strobe.
   always @(negedge clk) begin
      if (!rst && (we0 || we1)) begin
         wr_t e;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_write: got addr=%h data=%h, required no write", waddr0, wdata0);
         end else begin
            e = exp_q.pop_front();
            if ({we0, waddr0, wdata0} !== {1'b1, e.off, e.data}) begin
               n_bad++;
               $display("FAIL write0: got we=%b addr=%h data=%h, required addr=%h data=%h",
                        we0, waddr0, wdata0, e.off, e.data);
            end
            n_cmp++;
            if ({we1, waddr1, wdata1} !== {1'b1, e.off + 32'h100, e.data}) begin
               n_bad++;
               $display("FAIL write1: got we=%b addr=%h data=%h, required addr=%h data=%h",
                        we1, waddr1, wdata1, e.off + 32'h100, e.data);
            end
         end
         n_cmp++;
         if (cyc - last_we_cyc < 5) begin
            n_bad++;
            $display("FAIL write_spacing: got %0d cycles, required >= 5", cyc - last_we_cyc);
         end
         n_cmp++;
         if (in_ready0 !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_in_write: got in_ready=%b, required 0", in_ready0);
         end
         last_we_cyc = cyc;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish, required finish");
      $fatal(1, "timeout");
   end

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int t;
      if (gaps) begin
         while ($urandom_range(0, 2) == 0) begin
            @(negedge clk);
            in_valid = 1'b0;
         end
      end
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      t = 0;
      while (!in_ready0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         n_cmp++;
         n_bad++;
         $display("FAIL handshake_timeout: got in_ready=0 for 50 cycles, required 1");
      end
      @(posedge clk);
   endtask

   task automatic send_word(input logic [31:0] w, input bit gaps);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gaps);
   endtask

   task automatic stream_prog(input int n, input bit gaps);
      send_word(n, gaps);
      for (int k = 0; k < n; k++) begin
         exp_q.push_back('{off: 32'(4 * k), data: prog[k]});
         send_word(prog[k], gaps);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if ({in_ready0, busy0, done0, cpu_en0, err0} !== 5'b11000) begin
         n_bad++;
         $display("FAIL start_to_hdr: got rdy/busy/done/cpu_en/err=%b, required 11000",
                  {in_ready0, busy0, done0, cpu_en0, err0});
      end
   endtask

   task automatic wait_done(input int limit);
      int t = 0;
      while (!(done0 || err0) && t < limit) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (done0 !== 1'b1 || cpu_en0 !== 1'b1 || done1 !== 1'b1) begin
         n_bad++;
         $display("FAIL done_reached: got done=%b cpu_en=%b done1=%b, required 1 1 1",
                  done0, cpu_en0, done1);
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL writes_pending: got %0d outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      n_cmp++;
      if ({in_ready0, we0, cpu_en0, busy0, done0, err0} !== 6'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b, required 000000",
                  {in_ready0, we0, cpu_en0, busy0, done0, err0});
      end
      n_cmp++;
      if (wdata0 !== 32'h0 || waddr0 !== 32'h0 || waddr1 !== 32'h100) begin
         n_bad++;
         $display("FAIL reset_data: got wdata=%h waddr0=%h waddr1=%h, required 0 0 100",
                  wdata0, waddr0, waddr1);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_two_word();
      prog[0] = 32'h2008_0005;
      prog[1] = 32'h0000_000C;
      pulse_start();
      stream_prog(2, 1'b0);
      wait_done(20);
      n_cmp++;
      if (cyc - last_we_cyc !== 1) begin
         n_bad++;
         $display("FAIL done_latency: got %0d cycles after write, required 1", cyc - last_we_cyc);
      end
   endtask

   task automatic test_gaps();
      prog[0] = 32'h2008_0005;
      prog[1] = 32'h0000_000C;
      pulse_start();
      stream_prog(2, 1'b1);
      wait_done(50);
   endtask

   task automatic test_zero_hdr();
      int nw = last_we_cyc;
      pulse_start();
      send_word(32'h0, 1'b0);
      @(negedge clk);
      n_cmp++;
      if ({done0, cpu_en0, busy0, err0} !== 4'b1100) begin
         n_bad++;
         $display("FAIL zero_hdr: got done/cpu_en/busy/err=%b, required 1100",
                  {done0, cpu_en0, busy0, err0});
      end
      n_cmp++;
      if (last_we_cyc != nw) begin
         n_bad++;
         $display("FAIL zero_hdr_write: got write at cycle %0d, required none", last_we_cyc);
      end
   endtask

   task automatic test_err();
      pulse_start();
      send_word(32'd1025, 1'b0);
      @(negedge clk);
      n_cmp++;
      if ({err0, cpu_en0, done0, busy0, err1} !== 5'b10001) begin
         n_bad++;
         $display("FAIL hdr_too_big: got err/cpu_en/done/busy/err1=%b, required 10001",
                  {err0, cpu_en0, done0, busy0, err1});
      end
      prog[0] = 32'hDEAD_BEEF;
      pulse_start();
      stream_prog(1, 1'b0);
      wait_done(20);
   endtask

   task automatic test_three_words();
      prog[0] = 32'h1111_2222;
      prog[1] = 32'h3333_4444;
      prog[2] = 32'h5555_6666;
      pulse_start();
      stream_prog(3, 1'b1);
      wait_done(60);
   endtask

   task automatic test_rst_mid();
      pulse_start();
      send_word(32'd2, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({in_ready0, we0, cpu_en0, busy0, done0, err0} !== 6'b0 || wdata0 !== 32'h0 ||
          waddr0 !== 32'h0 || waddr1 !== 32'h100) begin
         n_bad++;
         $display("FAIL rst_mid: got ctrl=%b wdata=%h waddr0=%h waddr1=%h, required 0 0 0 100",
                  {in_ready0, we0, cpu_en0, busy0, done0, err0}, wdata0, waddr0, waddr1);
      end
      @(negedge clk);
      rst = 1'b0;
      prog[0] = 32'hCAFE_0001;
      prog[1] = 32'hCAFE_0002;
      pulse_start();
      stream_prog(2, 1'b0);
      wait_done(20);
   endtask

   task automatic test_start_ignored();
      prog[0] = 32'hA0A1_A2A3;
      prog[1] = 32'hB0B1_B2B3;
      prog[2] = 32'hC0C1_C2C3;
      pulse_start();
      send_word(32'd3, 1'b0);
      exp_q.push_back('{off: 32'd0, data: prog[0]});
      send_word(prog[0], 1'b0);
      exp_q.push_back('{off: 32'd4, data: prog[1]});
      send_byte(prog[1][31:24], 1'b0);
      send_byte(prog[1][23:16], 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if ({busy0, in_ready0, done0} !== 3'b110) begin
         n_bad++;
         $display("FAIL start_in_load: got busy/rdy/done=%b, required 110",
                  {busy0, in_ready0, done0});
      end
      send_byte(prog[1][15:8], 1'b0);
      send_byte(prog[1][7:0], 1'b0);
      exp_q.push_back('{off: 32'd8, data: prog[2]});
      send_word(prog[2], 1'b0);
      wait_done(20);
   endtask

   initial begin
      test_reset();
      test_two_word();
      test_gaps();
      test_zero_hdr();
      test_err();
      test_three_words();
      test_rst_mid();
      test_start_ignored();
      repeat (10) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
